// File: rtl/mem_port_arbiter_if.sv
// Signal bundle for the shared memory port arbiter: fetch request/response,
// data request/response and the memory-side handshake.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        if_stall;

  logic        dm_req;
  logic        dm_we;
  logic [1:0]  dm_size;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_valid;
  logic        dm_stall;
  logic        dm_misalign;

  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        mem_err;

  // Arbiter side.
  modport slave (
    input  if_req, if_addr,
    input  dm_req, dm_we, dm_size, dm_addr, dm_wdata,
    input  mem_rdata, mem_ack,
    output if_rdata, if_valid, if_stall,
    output dm_rdata, dm_valid, dm_stall, dm_misalign,
    output mem_req, mem_we, mem_size, mem_addr, mem_wdata, mem_err
  );

  // Pipeline and memory side.
  modport master (
    output if_req, if_addr,
    output dm_req, dm_we, dm_size, dm_addr, dm_wdata,
    output mem_rdata, mem_ack,
    input  if_rdata, if_valid, if_stall,
    input  dm_rdata, dm_valid, dm_stall, dm_misalign,
    input  mem_req, mem_we, mem_size, mem_addr, mem_wdata, mem_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data accesses:
// data-priority arbitration with a bounded data streak, misalignment rejection and an ack watchdog.
module mem_port_arbiter #(
  parameter int MAX_DATA_STREAK = 4,
  parameter int TIMEOUT         = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.slave bus
);

  localparam int SW = $clog2(MAX_DATA_STREAK + 1);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_e;

  typedef struct packed {
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] if_rdata;
    logic [31:0] dm_rdata;
    logic        if_valid;
    logic        dm_valid;
    logic        dm_misalign;
    logic        mem_err;
  } regs_t;

  state_e        state_q, state_n;
  regs_t         r_q, r_n;
  logic [SW-1:0] streak_q, streak_n;
  logic [7:0]    wdog_q, wdog_n;

  logic busy, ack, timeout, arb_en;
  logic i_elig, d_elig, grant_i, grant_d, misalign;

  // The requester being completed in an ack cycle sits out that cycle's arbitration.
  assign busy     = (state_q != IDLE);
  assign ack      = busy & bus.mem_ack;
  assign timeout  = busy & ~bus.mem_ack & (wdog_q == 8'(TIMEOUT - 1));
  assign arb_en   = ~busy | ack;
  assign i_elig   = bus.if_req & (state_q != BUSY_I);
  assign d_elig   = bus.dm_req & (state_q != BUSY_D);
  assign grant_i  = arb_en & i_elig & (~d_elig | (streak_q == SW'(MAX_DATA_STREAK)));
  assign grant_d  = arb_en & d_elig & ~grant_i;
  assign misalign = ((bus.dm_size == 2'b10) & (bus.dm_addr[1:0] != 2'b00)) |
                    ((bus.dm_size == 2'b01) & bus.dm_addr[0]);

  always_comb begin
    // NOTE: every variable gets a default first, so no path through this block can infer a latch.
    state_n          = state_q;
    r_n              = r_q;
    r_n.if_valid     = 1'b0;
    r_n.dm_valid     = 1'b0;
    r_n.dm_misalign  = 1'b0;
    r_n.mem_err      = 1'b0;
    wdog_n           = busy ? wdog_q + 8'd1 : wdog_q;
    streak_n         = streak_q;

    if (ack) begin
      state_n     = IDLE;
      r_n.mem_req = 1'b0;
      if (state_q == BUSY_I) begin
        r_n.if_valid = 1'b1;
        r_n.if_rdata = bus.mem_rdata;
      end else begin
        r_n.dm_valid = 1'b1;
        if (!r_q.mem_we) r_n.dm_rdata = bus.mem_rdata;
      end
    end else if (timeout) begin
      state_n     = IDLE;
      r_n.mem_req = 1'b0;
      r_n.mem_err = 1'b1;
      if (state_q == BUSY_I) begin
        r_n.if_valid = 1'b1;
        r_n.if_rdata = '0;
      end else begin
        r_n.dm_valid = 1'b1;
        r_n.dm_rdata = '0;
      end
    end

    // A new issue overrides the return-to-IDLE above, giving bubble-free hand-over.
    if (grant_i) begin
      state_n       = BUSY_I;
      r_n.mem_req   = 1'b1;
      r_n.mem_we    = 1'b0;
      r_n.mem_size  = 2'b10;
      r_n.mem_addr  = bus.if_addr;
      r_n.mem_wdata = '0;
      wdog_n        = '0;
    end else if (grant_d) begin
      if (misalign) begin
        r_n.dm_valid    = 1'b1;
        r_n.dm_misalign = 1'b1;
      end else begin
        state_n       = BUSY_D;
        r_n.mem_req   = 1'b1;
        r_n.mem_we    = bus.dm_we;
        r_n.mem_size  = bus.dm_size;
        r_n.mem_addr  = bus.dm_addr;
        r_n.mem_wdata = bus.dm_wdata;
        wdog_n        = '0;
      end
    end

    if (!bus.if_req || grant_i) begin
      streak_n = '0;
    end else if (grant_d && (streak_q != SW'(MAX_DATA_STREAK))) begin
      streak_n = streak_q + SW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      r_q      <= '0;
      streak_q <= '0;
      wdog_q   <= '0;
    end else begin
      state_q  <= state_n;
      r_q      <= r_n;
      streak_q <= streak_n;
      wdog_q   <= wdog_n;
    end
  end

  assign bus.mem_req     = r_q.mem_req;
  assign bus.mem_we      = r_q.mem_we;
  assign bus.mem_size    = r_q.mem_size;
  assign bus.mem_addr    = r_q.mem_addr;
  assign bus.mem_wdata   = r_q.mem_wdata;
  assign bus.mem_err     = r_q.mem_err;
  assign bus.if_rdata    = r_q.if_rdata;
  assign bus.if_valid    = r_q.if_valid;
  assign bus.dm_rdata    = r_q.dm_rdata;
  assign bus.dm_valid    = r_q.dm_valid;
  assign bus.dm_misalign = r_q.dm_misalign;
  assign bus.if_stall    = bus.if_req & ~r_q.if_valid;
  assign bus.dm_stall    = bus.dm_req & ~r_q.dm_valid;

endmodule
